// File: rtl/itch_pkg.sv
// Shared ITCH 5.0 constants, Add Order record and parser state encoding.
// Used by the add-order parser and the downstream order-book stage.
package itch_pkg;

    localparam logic [7:0]  MSG_TYPE_ADD  = 8'h41;
    localparam logic [15:0] ADD_ORDER_LEN = 16'd36;
    localparam logic [7:0]  SIDE_BUY      = 8'h42;
    localparam logic [7:0]  SIDE_SELL     = 8'h53;

    typedef struct packed {
        logic [15:0] stockLocate;
        logic [63:0] orderRef;
        logic        side;
        logic [31:0] shares;
        logic [31:0] price;
    } add_order_t;

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        TYPE,
        ADD_BODY,
        SKIP,
        DRAIN
    } parser_state_t;

endpackage

// File: rtl/itch_add_parser.sv
// Frames length-prefixed ITCH messages and extracts Add Order fields; 1 cycle after last byte.
// No backpressure: one byte per cycle accepted, errors drop the message and resync on the gap.
module itch_add_parser
    import itch_pkg::*;
#(
    parameter int IDLE_GAP = 16
) (
    input  logic        clkIn,
    input  logic        rstNIn,
    input  logic [7:0]  dataIn,
    input  logic        dataValidIn,
    input  logic        dataErrIn,
    output logic        addValidOut,
    output logic [15:0] stockLocateOut,
    output logic [63:0] orderRefOut,
    output logic        sideOut,
    output logic [31:0] sharesOut,
    output logic [31:0] priceOut,
    output logic        parseErrOut,
    output logic [15:0] errCntOut
);

    parser_state_t r_state;
    logic [7:0]    r_len_hi;
    logic [15:0]   r_len;
    logic [15:0]   r_cnt;
    logic [7:0]    r_gap;
    logic          r_bad;
    add_order_t    r_sh;
    add_order_t    r_out;
    logic          r_add_vld;
    logic          r_perr;
    logic [15:0]   r_err_cnt;

    logic [15:0]   w_len_full;
    logic          w_gap_exp;
    logic          w_in_msg;
    logic          w_perr;

    assign w_len_full = {r_len_hi, dataIn};
    assign w_gap_exp  = !dataValidIn && !dataErrIn && (r_gap == 8'(IDLE_GAP - 1));
    assign w_in_msg   = (r_state == LEN_LO) || (r_state == TYPE) ||
                        (r_state == ADD_BODY) || (r_state == SKIP);

    always_comb begin
        w_perr = 1'b0;
        if (dataErrIn) begin
            w_perr = 1'b1;
        end else if (dataValidIn) begin
            case (r_state)
                LEN_LO:   w_perr = (w_len_full == 16'd0);
                TYPE:     w_perr = (dataIn == MSG_TYPE_ADD) && (r_len != ADD_ORDER_LEN);
                ADD_BODY: w_perr = (r_cnt == 16'd35) && r_bad;
                default:  w_perr = 1'b0;
            endcase
        end else begin
            w_perr = w_gap_exp && w_in_msg;
        end
    end

    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            r_state   <= LEN_HI;
            r_len_hi  <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_gap     <= '0;
            r_bad     <= 1'b0;
            r_sh      <= '0;
            r_out     <= '0;
            r_add_vld <= 1'b0;
            r_perr    <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_add_vld <= 1'b0;
            r_perr    <= w_perr;
            if (w_perr && (r_err_cnt != 16'hFFFF))
                r_err_cnt <= r_err_cnt + 16'd1;

            // Error cycles restart the gap so DRAIN always waits a full quiet period.
            if (dataValidIn || dataErrIn)
                r_gap <= '0;
            else if (r_gap != 8'(IDLE_GAP))
                r_gap <= r_gap + 8'd1;

            if (dataErrIn) begin
                r_state <= DRAIN;
            end else if (dataValidIn) begin
                case (r_state)
                    LEN_HI: begin
                        r_len_hi <= dataIn;
                        r_state  <= LEN_LO;
                    end
                    LEN_LO: begin
                        r_len   <= w_len_full;
                        r_state <= (w_len_full == 16'd0) ? LEN_HI : TYPE;
                    end
                    TYPE: begin
                        r_cnt <= 16'd1;
                        r_bad <= 1'b0;
                        if ((dataIn == MSG_TYPE_ADD) && (r_len == ADD_ORDER_LEN))
                            r_state <= ADD_BODY;
                        else if (r_len == 16'd1)
                            r_state <= LEN_HI;
                        else
                            r_state <= SKIP;
                    end
                    ADD_BODY: begin
                        if (r_cnt inside {[16'd1:16'd2]})
                            r_sh.stockLocate <= {r_sh.stockLocate[7:0], dataIn};
                        if (r_cnt inside {[16'd11:16'd18]})
                            r_sh.orderRef <= {r_sh.orderRef[55:0], dataIn};
                        if (r_cnt == 16'd19) begin
                            r_sh.side <= (dataIn == SIDE_BUY);
                            r_bad     <= (dataIn != SIDE_BUY) && (dataIn != SIDE_SELL);
                        end
                        if (r_cnt inside {[16'd20:16'd23]})
                            r_sh.shares <= {r_sh.shares[23:0], dataIn};
                        if (r_cnt inside {[16'd32:16'd35]})
                            r_sh.price <= {r_sh.price[23:0], dataIn};

                        if (r_cnt == 16'd35) begin
                            r_state <= LEN_HI;
                            if (!r_bad) begin
                                // Last price byte bypasses the shadow so the commit lands this edge.
                                r_out       <= r_sh;
                                r_out.price <= {r_sh.price[23:0], dataIn};
                                r_add_vld   <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                    SKIP: begin
                        if (r_cnt == 16'(r_len - 16'd1))
                            r_state <= LEN_HI;
                        else
                            r_cnt <= r_cnt + 16'd1;
                    end
                    default: r_state <= r_state;
                endcase
            end else if (w_gap_exp) begin
                r_state <= LEN_HI;
            end
        end
    end

    assign addValidOut    = r_add_vld;
    assign stockLocateOut = r_out.stockLocate;
    assign orderRefOut    = r_out.orderRef;
    assign sideOut        = r_out.side;
    assign sharesOut      = r_out.shares;
    assign priceOut       = r_out.price;
    assign parseErrOut    = r_perr;
    assign errCntOut      = r_err_cnt;

endmodule

// File: tb/tb_itch_add_parser.sv
// Directed bench for itch_add_parser: hand-built byte streams with hand-computed fields.
module tb_itch_add_parser;

    logic        clkIn = 1'b0;
    logic        rstNIn = 1'b0;
    logic [7:0]  dataIn = '0;
    logic        dataValidIn = 1'b0;
    logic        dataErrIn = 1'b0;
    logic        addValidOut;
    logic [15:0] stockLocateOut;
    logic [63:0] orderRefOut;
    logic        sideOut;
    logic [31:0] sharesOut;
    logic [31:0] priceOut;
    logic        parseErrOut;
    logic [15:0] errCntOut;

    int n_cmp = 0;
    int n_bad = 0;
    int n_add = 0;
    int n_err = 0;
    int add0, err0;

    itch_add_parser #(.IDLE_GAP(16)) dut (
        .clkIn          (clkIn),
        .rstNIn         (rstNIn),
        .dataIn         (dataIn),
        .dataValidIn    (dataValidIn),
        .dataErrIn      (dataErrIn),
        .addValidOut    (addValidOut),
        .stockLocateOut (stockLocateOut),
        .orderRefOut    (orderRefOut),
        .sideOut        (sideOut),
        .sharesOut      (sharesOut),
        .priceOut       (priceOut),
        .parseErrOut    (parseErrOut),
        .errCntOut      (errCntOut)
    );

    always #2 clkIn = ~clkIn;

    always @(negedge clkIn) begin
        if (rstNIn) begin
            if (addValidOut) n_add++;
            if (parseErrOut) n_err++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clkIn);
            #1;
        end
    endtask

    task automatic put(input logic [7:0] b, input logic e);
        dataIn      = b;
        dataValidIn = 1'b1;
        dataErrIn   = e;
        @(posedge clkIn);
        #1;
        dataValidIn = 1'b0;
        dataErrIn   = 1'b0;
    endtask

    // Stream index = body byte + 2; sends indices 0..last, err flagged on err_at.
    task automatic send_add(input logic [15:0] loc, input logic [63:0] oref, input logic [7:0] side,
                            input logic [31:0] sh, input logic [31:0] pr,
                            input int gap, input int last, input int err_at);
        logic [7:0] m [38];
        for (int i = 0; i < 38; i++) m[i] = 8'h00;
        m[1] = 8'h24;
        m[2] = 8'h41;
        m[3] = loc[15:8];
        m[4] = loc[7:0];
        for (int k = 0; k < 8; k++) m[13 + k] = oref[63 - 8*k -: 8];
        m[21] = side;
        for (int k = 0; k < 4; k++) m[22 + k] = sh[31 - 8*k -: 8];
        for (int k = 0; k < 8; k++) m[26 + k] = 8'h20;
        for (int k = 0; k < 4; k++) m[34 + k] = pr[31 - 8*k -: 8];
        for (int i = 0; i <= last; i++) begin
            put(m[i], i == err_at);
            if (i < last) idle(gap);
        end
    endtask

    task automatic expect_add(input string tag, input logic [15:0] loc, input logic [63:0] oref,
                              input logic sd, input logic [31:0] sh, input logic [31:0] pr);
        chk({tag, "_vld"},   addValidOut,    1);
        chk({tag, "_loc"},   stockLocateOut, loc);
        chk({tag, "_ref"},   orderRefOut,    oref);
        chk({tag, "_side"},  sideOut,        sd);
        chk({tag, "_shr"},   sharesOut,      sh);
        chk({tag, "_price"}, priceOut,       pr);
    endtask

    initial begin
        // Reset state
        idle(2);
        chk("rst_vld",   addValidOut, 0);
        chk("rst_perr",  parseErrOut, 0);
        chk("rst_cnt",   errCntOut,   0);
        chk("rst_ref",   orderRefOut, 0);
        chk("rst_price", priceOut,    0);
        rstNIn = 1'b1;
        idle(2);

        // Add Order 'B', bytes every other cycle
        send_add(16'h0102, 64'h1122334455667788, 8'h42, 32'd100, 32'h0001E240, 1, 37, -1);
        expect_add("add1", 16'h0102, 64'h1122334455667788, 1'b1, 32'd100, 32'h0001E240);
        idle(1);
        chk("add1_pulse_width", addValidOut, 0);
        idle(5);
        chk("add1_hold_price", priceOut, 32'h0001E240);
        chk("add1_n_add", n_add, 1);
        chk("add1_n_err", n_err, 0);

        // 'S' message L=12 skipped, then back-to-back Add Order with side 'S'
        put(8'h00, 1'b0);
        put(8'h0C, 1'b0);
        put(8'h53, 1'b0);
        for (int i = 0; i < 11; i++) put(8'h53, 1'b0);
        send_add(16'h0A0B, 64'hDEADBEEF00000001, 8'h53, 32'd500, 32'h12345678, 0, 37, -1);
        expect_add("add2", 16'h0A0B, 64'hDEADBEEF00000001, 1'b0, 32'd500, 32'h12345678);
        idle(1);
        chk("skip_n_add", n_add, 2);
        chk("skip_errcnt", errCntOut, 0);

        // dataErrIn at body byte 15, 20-cycle gap, then a clean Add Order
        send_add(16'h3333, 64'hAAAAAAAAAAAAAAAA, 8'h42, 32'd7, 32'd7, 1, 17, 17);
        chk("derr_perr", parseErrOut, 1);
        chk("derr_cnt", errCntOut, 1);
        idle(20);
        send_add(16'hFFFF, 64'h0102030405060708, 8'h42, 32'd1, 32'd1, 1, 37, -1);
        expect_add("add3", 16'hFFFF, 64'h0102030405060708, 1'b1, 32'd1, 32'd1);
        idle(1);
        chk("derr_n_add", n_add, 3);
        chk("derr_n_err", n_err, 1);

        // Truncation after body byte 20: error exactly on the 16th idle edge
        send_add(16'h4444, 64'h5555, 8'h53, 32'd9, 32'd9, 1, 22, -1);
        idle(15);
        chk("trunc_early", parseErrOut, 0);
        idle(1);
        chk("trunc_perr", parseErrOut, 1);
        chk("trunc_cnt", errCntOut, 2);
        send_add(16'h0007, 64'h00000000000000FF, 8'h53, 32'h01020304, 32'h7FFFFFFF, 1, 37, -1);
        expect_add("add4", 16'h0007, 64'h00000000000000FF, 1'b0, 32'h01020304, 32'h7FFFFFFF);
        idle(3);

        // Bad length, wrong-length 'A', bad side: from a fresh reset
        rstNIn = 1'b0;
        idle(1);
        rstNIn = 1'b1;
        idle(2);
        add0 = n_add;
        put(8'h00, 1'b0);
        put(8'h00, 1'b0);
        chk("len0_perr", parseErrOut, 1);
        put(8'h00, 1'b0);
        put(8'h1E, 1'b0);
        put(8'h41, 1'b0);
        chk("len30_perr", parseErrOut, 1);
        for (int i = 0; i < 29; i++) put(8'h41, 1'b0);
        chk("len30_skip_quiet", parseErrOut, 0);
        send_add(16'h1234, 64'h1, 8'h58, 32'd2, 32'd2, 1, 37, -1);
        chk("badside_perr", parseErrOut, 1);
        chk("badside_vld", addValidOut, 0);
        chk("bad_cnt", errCntOut, 3);
        idle(2);
        chk("bad_n_add", n_add - add0, 0);

        // Reset mid-message at body byte 10
        send_add(16'h9999, 64'h9999, 8'h42, 32'd9, 32'd9, 1, 12, -1);
        rstNIn = 1'b0;
        idle(2);
        chk("midrst_vld",   addValidOut,    0);
        chk("midrst_loc",   stockLocateOut, 0);
        chk("midrst_price", priceOut,       0);
        chk("midrst_cnt",   errCntOut,      0);
        rstNIn = 1'b1;
        add0 = n_add;
        err0 = n_err;
        idle(4);
        send_add(16'h0102, 64'hCAFEF00DCAFEF00D, 8'h53, 32'd100, 32'h0001E240, 1, 37, -1);
        expect_add("add5", 16'h0102, 64'hCAFEF00DCAFEF00D, 1'b0, 32'd100, 32'h0001E240);
        idle(2);
        chk("midrst_n_add", n_add - add0, 1);
        chk("midrst_n_err", n_err - err0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/itch_add_parser.md
# itch_add_parser

Byte-stream framer/parser in the 250 MHz domain. It consumes the byte, valid and error outputs of the 125→250 MHz CDC stage, frames length-prefixed ITCH 5.0 messages, and extracts Add Order ('A') fields for the downstream order-book stage. All other message types are skipped. Malformed or corrupted messages are dropped, and the parser resynchronises on the inter-packet gap.

## Interface
- IDLE_GAP, 16: consecutive cycles without a valid byte that mark a packet boundary; range 4..255.
- clkIn  in  1  250 MHz clock. Single clock domain.
- rstNIn  in  1  reset; asynchronous, active-low.
- dataIn  in  8  byte from CDC stage.
- dataValidIn  in  1  dataIn valid this cycle. At most one per cycle; typically every other cycle.
- dataErrIn  in  1  CDC integrity error this cycle; the byte is untrusted.
- addValidOut  out  1  one-cycle pulse; field outputs are valid.
- stockLocateOut  out  16  message bytes 1–2.
- orderRefOut  out  64  message bytes 11–18.
- sideOut  out  1  1 = buy ('B', 0x42), 0 = sell ('S', 0x53).
- sharesOut  out  32  message bytes 20–23.
- priceOut  out  32  message bytes 32–35, 4 implied decimals.
- parseErrOut  out  1  one-cycle pulse per dropped message.
- errCntOut  out  16  saturating count of parseErrOut pulses.

## Operation
- Framing: 2-byte big-endian length L, then L message bytes. Byte 0 is the type. All fields are big-endian.
- Add Order requires L = 36, type 0x41. Byte layout:
  - byte 1–2: locate
  - byte 3–4: tracking (discarded)
  - byte 5–10: timestamp (discarded)
  - byte 11–18: orderRef
  - byte 19: side
  - byte 20–23: shares
  - byte 24–31: stock (discarded)
  - byte 32–35: price
- FSM states: LEN_HI, LEN_LO, TYPE, ADD_BODY, SKIP, DRAIN. Reset state is LEN_HI.
  - LEN_HI → LEN_LO on valid byte.
  - LEN_LO: L = 0 → parse error, back to LEN_HI. Otherwise → TYPE.
  - TYPE: type 0x41 with L = 36 → ADD_BODY. Type 0x41 with L ≠ 36 → parse error, SKIP. Other type with L = 1 → LEN_HI. Other type → SKIP.
  - SKIP: consume the remaining L−1 bytes, then → LEN_HI, no error.
  - ADD_BODY: byte counter 1..35. Capture fields into shadow registers.
    - Side byte not 0x42/0x53: error latched, remaining bytes consumed, error reported at byte 35.
    - Byte 35 accepted with no error: shadow registers copied to outputs, addValidOut pulses.
  - DRAIN: discard all bytes until the gap timer expires, then → LEN_HI.
- dataErrIn = 1 in any state: parse error pulse, → DRAIN. A dataErrIn cycle never advances the counters.
- Gap timer:
  - Counts cycles without dataValidIn; cleared on any valid byte.
  - Expiry at IDLE_GAP in LEN_LO, TYPE, ADD_BODY or SKIP: truncation → parse error, → LEN_HI.
  - Expiry in LEN_HI: no effect.
  - Expiry in DRAIN: → LEN_HI, no error.
- Simultaneous dataValidIn and dataErrIn: treated as an error only. The byte is discarded.
- Field outputs hold their value between pulses. The shadow registers are not visible until commit.
- errCntOut saturates at 0xFFFF.

## Timing
- Reset values: all outputs 0, FSM in LEN_HI, counters and gap timer 0.
- Assertion of rstNIn mid-message aborts immediately. No pulse is emitted, and nothing is emitted after release.
- addValidOut rises the cycle after the clock edge sampling byte 35. All field outputs update on that same edge.
- parseErrOut rises the cycle after the error-causing edge:
  - the dataErrIn byte,
  - the L or type byte,
  - byte 35 for a bad side,
  - the gap-expiry edge for truncation.
- errCntOut increments on the same edge parseErrOut rises.
- No backpressure: every valid byte is accepted. The block sustains one byte per cycle.
- Latency from the first length byte to addValidOut is 38 valid-byte beats plus 1 cycle.

## Structure
- itch_pkg (shared with the order book) contains:
  - MSG_TYPE_ADD = 8'h41, ADD_ORDER_LEN = 16'd36
  - SIDE_BUY = 8'h42, SIDE_SELL = 8'h53
  - typedef add_order_t struct {stockLocate, orderRef, side, shares, price}
  - enum parser_state_t
- Single module, no sub-modules. Field capture is a byte-index-addressed shift into add_order_t shadow registers.

## Test plan
- Add Order, 0x0024 then 'A':
  - stimulus: locate 0x0102, orderRef 0x1122334455667788, side 'B', shares 100, price 0x0001E240, bytes every other cycle
  - required response: one addValidOut pulse the cycle after byte 35 with exactly those fields and sideOut = 1, parseErrOut never asserts.
- Message type 'S' with L = 12, followed by an Add Order with side 'S':
  - required response: the 'S' message produces no pulse, the Add Order produces one pulse with sideOut = 0, errCntOut = 0.
- dataErrIn at body byte 15, 20-cycle gap, then a valid Add Order:
  - required response: one parseErrOut pulse, errCntOut = 1, no pulse for the corrupted message, the following Add Order pulses correctly.
- Truncation: Add Order stops after byte 20, then idle for 16 cycles:
  - required response: parseErrOut pulses on the gap-expiry edge, FSM returns to LEN_HI, the next message parses.
- Bad lengths and bad side:
  - L = 0 → one error.
  - 'A' with L = 30 → one error, the 29 remaining bytes are skipped.
  - side 0x58 → one error at byte 35.
  - Required response: three pulses total, errCntOut = 3, no addValidOut.
- rstNIn asserted at body byte 10, released, then an Add Order:
  - required response: outputs read 0 during reset, no stale pulse, exactly one valid pulse for the new message.
